// File: rtl/contador_lectura_ctrl.sv
// Reads the four contador pop counters (idx 0..3) in order, capturing each response
// and flagging any index whose valid_contador does not arrive within TIMEOUT cycles.
module contador_lectura_ctrl #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             IDLE,
    input  logic             valid_contador,
    input  logic [CNT_W-1:0] contador_out,
    output logic             req,
    output logic [1:0]       idx,
    output logic [CNT_W-1:0] cnt_F0,
    output logic [CNT_W-1:0] cnt_F1,
    output logic [CNT_W-1:0] cnt_F2,
    output logic [CNT_W-1:0] cnt_F3,
    output logic             busy,
    output logic             done,
    output logic [3:0]       err_flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_ADV  = 2'd3
    } state_t;

    // Last wait cycle: a valid sampled on this cycle still wins over the timeout.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t           state_r;
    logic             pending_r;
    logic [3:0]       tcnt_r;
    logic             req_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic             busy_r;
    logic             done_r;
    logic [3:0]       err_r;

    // Sweep sequencer: state, request pulse, response capture and timeout tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pending_r <= 1'b0;
            tcnt_r    <= 4'd0;
            req_r     <= 1'b0;
            idx_r     <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            req_r  <= 1'b0;
            done_r <= 1'b0;
            // A start arriving while a sweep is active (including the done cycle) is remembered once.
            if (start && (state_r != S_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    if (start || pending_r) begin
                        err_r     <= 4'd0;
                        pending_r <= 1'b0;
                        idx_r     <= 2'd0;
                        busy_r    <= 1'b1;
                        state_r   <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (IDLE) begin
                        req_r   <= 1'b1;
                        tcnt_r  <= 4'd0;
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (valid_contador) begin
                        cnt_r[idx_r] <= contador_out;
                        state_r      <= S_ADV;
                    end else if (tcnt_r == TMO_LAST) begin
                        err_r[idx_r] <= 1'b1;
                        state_r      <= S_ADV;
                    end else begin
                        tcnt_r <= tcnt_r + 4'd1;
                    end
                end
                S_ADV: begin
                    if (idx_r == 2'd3) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        idx_r   <= 2'd0;
                        state_r <= S_IDLE;
                    end else begin
                        idx_r   <= idx_r + 2'd1;
                        state_r <= S_ARM;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign req       = req_r;
    assign idx       = idx_r;
    assign cnt_F0    = cnt_r[0];
    assign cnt_F1    = cnt_r[1];
    assign cnt_F2    = cnt_r[2];
    assign cnt_F3    = cnt_r[3];
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_flags = err_r;

endmodule

// File: tb/tb_contador_lectura_ctrl.sv
// Self-checking bench for contador_lectura_ctrl: a contador response model plus
// a scoreboard of expected request indices and per-sweep captured results.
module tb_contador_lectura_ctrl;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             IDLE;
    logic             valid_contador;
    logic [CNT_W-1:0] contador_out;
    logic             req;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt_F0, cnt_F1, cnt_F2, cnt_F3;
    logic             busy;
    logic             done;
    logic [3:0]       err_flags;

    typedef struct packed {
        logic [3:0]  err;
        logic [19:0] cnts;
    } sweep_t;

    sweep_t     sb_q[$];
    logic [1:0] exp_idx_q[$];

    int         vectors     = 0;
    int         miscompares = 0;
    int         done_cnt    = 0;

    // Contador model: per-index value and response delay (-1 = never answers).
    logic [4:0] resp_val [4];
    int         resp_dly [4];
    logic [4:0] model_cnt [4];
    logic [3:0] model_err;
    int         stray_req = 0;

    contador_lectura_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
        .valid_contador(valid_contador), .contador_out(contador_out),
        .req(req), .idx(idx),
        .cnt_F0(cnt_F0), .cnt_F1(cnt_F1), .cnt_F2(cnt_F2), .cnt_F3(cnt_F3),
        .busy(busy), .done(done), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // Responder: sees req at the falling edge, answers resp_dly falling edges later.
    initial begin
        int         rsp_cnt;
        int         stray_ack;
        logic [1:0] rsp_idx;
        rsp_cnt = -1;
        stray_ack = 0;
        rsp_idx = 2'd0;
        valid_contador = 1'b0;
        contador_out = 5'd0;
        forever begin
            @(negedge clk);
            valid_contador = 1'b0;
            if (req === 1'b1) begin
                rsp_idx = idx;
                rsp_cnt = resp_dly[idx];
            end
            if (rsp_cnt == 0) begin
                valid_contador = 1'b1;
                contador_out = resp_val[rsp_idx];
                rsp_cnt = -1;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
            end
            if (stray_req != stray_ack) begin
                valid_contador = 1'b1;
                contador_out = 5'd31;
                stray_ack = stray_req;
            end
        end
    end

    // Monitor: pops expected idx on every req and expected results on every done.
    initial begin
        sweep_t     s;
        logic [1:0] ei;
        forever begin
            @(negedge clk);
            if (req === 1'b1) begin
                vectors++;
                if (exp_idx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: got req idx=%0d, required no req", idx);
                end else begin
                    ei = exp_idx_q.pop_front();
                    if (idx !== ei) begin
                        miscompares++;
                        $display("FAIL req_idx: got %0d, required %0d", idx, ei);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: got done, required none");
                end else begin
                    s = sb_q.pop_front();
                    if ({cnt_F3, cnt_F2, cnt_F1, cnt_F0} !== s.cnts) begin
                        miscompares++;
                        $display("FAIL sweep_counts: got F3..F0=%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d",
                                 cnt_F3, cnt_F2, cnt_F1, cnt_F0,
                                 s.cnts[19:15], s.cnts[14:10], s.cnts[9:5], s.cnts[4:0]);
                    end
                    vectors++;
                    if (err_flags !== s.err) begin
                        miscompares++;
                        $display("FAIL sweep_err: got %b, required %b", err_flags, s.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void push_sweep();
        sweep_t s;
        s.err = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (resp_dly[i] >= 0 && resp_dly[i] <= TIMEOUT - 1) begin
                model_cnt[i] = resp_val[i];
            end else begin
                s.err[i] = 1'b1;
            end
            exp_idx_q.push_back(2'(i));
        end
        s.cnts = {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]};
        model_err = s.err;
        sb_q.push_back(s);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_done: got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic wait_req(input logic [1:0] i, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req === 1'b1 && idx === i) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_req: got no req idx=%0d in %0d cycles, required req", i, budget);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        logic [28:0] obs;
        obs = {req, idx, busy, done, err_flags, cnt_F3, cnt_F2, cnt_F1, cnt_F0};
        vectors++;
        if (obs !== 29'd0) begin
            miscompares++;
            $display("FAIL %s: got outputs %h, required all zero", name, obs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({req, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got req,busy,done=%b, required 000", {req, busy, done});
        end
    endtask

    task automatic test_basic();
        int d0;
        resp_val = '{5'd0, 5'd1, 5'd3, 5'd1};
        resp_dly = '{1, 1, 1, 1};
        push_sweep();
        d0 = done_cnt;
        pulse_start();
        vectors++;
        if ({busy, req} !== 2'b10) begin
            miscompares++;
            $display("FAIL start_busy: got busy,req=%b, required 10", {busy, req});
        end
        @(negedge clk);
        vectors++;
        if ({req, idx} !== 3'b100) begin
            miscompares++;
            $display("FAIL first_req: got req,idx=%b, required 100", {req, idx});
        end
        wait_done(100);
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL done_pulse: got done,busy=%b pulses=%0d, required 00 and 1", {done, busy}, done_cnt - d0);
        end
    endtask

    task automatic test_latency();
        int  n;
        bit  seen;
        resp_val = '{5'd9, 5'd17, 5'd25, 5'd31};
        resp_dly = '{0, 0, 0, 0};
        push_sweep();
        n = 0;
        seen = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || n != 13) begin
            miscompares++;
            $display("FAIL best_case_latency: got %0d cycles (seen=%0d), required 13", n, seen);
        end
    endtask

    task automatic test_idle_gating();
        resp_val = '{5'd7, 5'd9, 5'd2, 5'd30};
        resp_dly = '{1, 1, 1, 1};
        push_sweep();
        IDLE = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if ({req, idx, busy} !== 4'b0001) begin
                miscompares++;
                $display("FAIL idle_hold_start: got req,idx,busy=%b, required 0001", {req, idx, busy});
            end
        end
        IDLE = 1'b1;
        wait_req(2'd1, 50);
        IDLE = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (req !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold_mid: got req=%b, required 0", req);
            end
        end
        vectors++;
        if (idx !== 2'd2) begin
            miscompares++;
            $display("FAIL idle_hold_idx: got %0d, required 2", idx);
        end
        IDLE = 1'b1;
        wait_done(100);
    endtask

    task automatic test_boundary();
        resp_val = '{5'd11, 5'd22, 5'd3, 5'd4};
        resp_dly = '{TIMEOUT - 1, TIMEOUT, 0, 0};
        push_sweep();
        pulse_start();
        wait_done(150);
    endtask

    task automatic test_timeout();
        int n;
        resp_val = '{5'd8, 5'd14, 5'd0, 5'd1};
        resp_dly = '{1, 1, -1, 1};
        push_sweep();
        pulse_start();
        wait_req(2'd2, 50);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (req === 1'b1) break;
        end
        vectors++;
        if (n != TIMEOUT + 2 || idx !== 2'd3) begin
            miscompares++;
            $display("FAIL timeout_length: got next req after %0d cycles idx=%0d, required %0d and 3",
                     n, idx, TIMEOUT + 2);
        end
        wait_done(100);
    endtask

    task automatic test_stray_valid();
        int d0;
        d0 = done_cnt;
        stray_req++;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cnt_F3, cnt_F2, cnt_F1, cnt_F0} !== {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]}
            || err_flags !== model_err || busy !== 1'b0 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL stray_valid: got F3..F0=%0d,%0d,%0d,%0d err=%b busy=%b, required %0d,%0d,%0d,%0d err=%b busy=0",
                     cnt_F3, cnt_F2, cnt_F1, cnt_F0, err_flags, busy,
                     model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0], model_err);
        end
    endtask

    task automatic test_pending();
        int d0;
        resp_val = '{5'd0, 5'd1, 5'd3, 5'd1};
        resp_dly = '{1, 1, 1, 1};
        push_sweep();
        push_sweep();
        d0 = done_cnt;
        pulse_start();
        wait_req(2'd1, 50);
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_done(100);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_gap: got busy=%b at done, required 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pending_restart: got busy=%b, required 1", busy);
        end
        wait_done(100);
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt != d0 + 2 || busy !== 1'b0 || exp_idx_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_once: got %0d sweeps busy=%b left=%0d, required 2 sweeps busy=0 left=0",
                     done_cnt - d0, busy, exp_idx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        resp_val = '{5'd2, 5'd4, 5'd6, 5'd8};
        resp_dly = '{1, 1, 1, 1};
        push_sweep();
        push_sweep();
        d0 = done_cnt;
        pulse_start();
        wait_req(2'd3, 100);
        repeat (2) @(negedge clk);
        pulse_start();
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_done: got done,busy=%b, required 10", {done, busy});
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart: got busy=%b, required 1", busy);
        end
        wait_done(100);
        repeat (10) @(negedge clk);
        vectors++;
        if (done_cnt != d0 + 2) begin
            miscompares++;
            $display("FAIL b2b_sweeps: got %0d sweeps, required 2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        resp_val = '{5'd10, 5'd20, 5'd30, 5'd31};
        resp_dly = '{1, -1, 1, 1};
        exp_idx_q.push_back(2'd0);
        exp_idx_q.push_back(2'd1);
        pulse_start();
        wait_req(2'd1, 50);
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check_zero_outputs("reset_mid_sweep");
        reset = 1'b0;
        exp_idx_q.delete();
        for (int i = 0; i < 4; i++) model_cnt[i] = 5'd0;
        model_err = 4'd0;
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done busy=%b, required 0 done busy=0", done_cnt - d0, busy);
        end
        resp_val = '{5'd5, 5'd6, 5'd7, 5'd8};
        resp_dly = '{1, 1, 1, 1};
        push_sweep();
        pulse_start();
        wait_done(100);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        IDLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resp_val[i] = 5'd0;
            resp_dly[i] = -1;
            model_cnt[i] = 5'd0;
        end
        model_err = 4'd0;
        test_reset();
        test_basic();
        test_latency();
        test_idle_gating();
        test_boundary();
        test_timeout();
        test_stray_valid();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
